detector_jogada: RTL and testbench

- Upstream input stage of the memory-game datapath: filters the raw push-buttons and feeds the game control unit.
- Debounces N_BOTOES buttons and emits a single-cycle `jogada` pulse with the registered one-hot button code.
- Runs the per-move timeout timer and raises `timeout` when no valid move arrives in time.
- The control unit enables it (`habilita`) only while waiting for a move and clears the timer via `zeraT`.

---
 rtl/detector_jogada_pkg.sv | 12 +
 rtl/detector_jogada_contador_m.sv | 28 ++
 rtl/detector_jogada.sv | 111 +++++++++++
 tb/tb_detector_jogada.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/detector_jogada_pkg.sv
// Shared definitions for the button-move detector: FSM state encoding,
// also decoded by the display logic through db_estado.
package detector_jogada_pkg;

   typedef enum logic [1:0] {
      LIVRE  = 2'd0,
      FILTRO = 2'd1,
      PULSO  = 2'd2,
      SOLTAR = 2'd3
   } estado_t;

endpackage

// File: rtl/detector_jogada_contador_m.sv
// Modulo-M up counter with synchronous clear (zera), enable (conta) and
// a terminal-count flag (fim) raised while the count equals M-1.
module contador_m #(
   parameter int M = 50000,
   localparam int W = (M > 1) ? $clog2(M) : 1
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   logic [W-1:0] valor;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valor <= '0;
      end else if (zera) begin
         valor <= '0;
      end else if (conta) begin
         valor <= fim ? '0 : valor + W'(1);
      end
   end

   assign fim = (valor == W'(M - 1));

endmodule

// File: rtl/detector_jogada.sv
// Push-button move detector: debounces the buttons, emits a one-cycle
// jogada pulse with the one-hot button code and runs the per-move timeout.
module detector_jogada
   import detector_jogada_pkg::*;
#(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int TIMEOUT_CICLOS  = 250000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   input  logic                zeraT,
   output logic                jogada,
   output logic [N_BOTOES-1:0] botao_codigo,
   output logic                timeout,
   output logic [1:0]          db_estado
);

   estado_t             estado;
   logic [N_BOTOES-1:0] candidato;
   logic                zeraD, contaD, fimD;
   logic                zeraTimer, contaTimer, fimT, timerAtivo;

   function automatic logic exatamenteUm(input logic [N_BOTOES-1:0] v);
      return (v != '0) && ((v & (v - {{(N_BOTOES-1){1'b0}}, 1'b1})) == '0);
   endfunction

   // The debounce counter measures stability of the candidate in FILTRO and
   // of the all-released condition in SOLTAR; it idles at zero elsewhere.
   always_comb begin
      zeraD  = 1'b0;
      contaD = 1'b0;
      case (estado)
         FILTRO: contaD = habilita && (botoes == candidato);
         SOLTAR: begin
            zeraD  = (botoes != '0);
            contaD = (botoes == '0);
         end
         default: zeraD = 1'b1;
      endcase
   end

   // The timer stops itself at its last value so timeout holds without wrapping.
   assign timerAtivo = habilita && !timeout && (estado == LIVRE || estado == FILTRO);
   assign zeraTimer  = !habilita || zeraT || (estado == PULSO);
   assign contaTimer = timerAtivo && !fimT;

   contador_m #(.M(DEBOUNCE_CICLOS)) contDebounce (
      .clock (clock),
      .reset (reset),
      .zera  (zeraD),
      .conta (contaD),
      .fim   (fimD)
   );

   contador_m #(.M(TIMEOUT_CICLOS)) contTimeout (
      .clock (clock),
      .reset (reset),
      .zera  (zeraTimer),
      .conta (contaTimer),
      .fim   (fimT)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado       <= LIVRE;
         jogada       <= 1'b0;
         botao_codigo <= '0;
         timeout      <= 1'b0;
         candidato    <= '0;
      end else begin
         jogada <= 1'b0;
         if (zeraTimer) begin
            timeout <= 1'b0;
         end else if (timerAtivo && fimT) begin
            timeout <= 1'b1;
         end
         case (estado)
            LIVRE: begin
               if (botoes != '0) begin
                  if (habilita && exatamenteUm(botoes)) begin
                     candidato <= botoes;
                     estado    <= FILTRO;
                  end else begin
                     estado <= SOLTAR;
                  end
               end
            end
            FILTRO: begin
               if (!habilita)                estado <= SOLTAR;
               else if (botoes != candidato) estado <= LIVRE;
               else if (fimD)                estado <= PULSO;
            end
            PULSO: begin
               jogada       <= 1'b1;
               botao_codigo <= candidato;
               estado       <= SOLTAR;
            end
            SOLTAR: begin
               if (botoes == '0 && fimD) estado <= LIVRE;
            end
            default: estado <= LIVRE;
         endcase
      end
   end

   assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with short debounce/timeout constants.
module tb_detector_jogada;
   import detector_jogada_pkg::*;

   localparam int NB = 4;
   localparam int DB = 4;
   localparam int TO = 20;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [NB-1:0] botoes = '0;
   logic          habilita = 1'b0;
   logic          zeraT = 1'b0;
   logic          jogada;
   logic [NB-1:0] botao_codigo;
   logic          timeout;
   logic [1:0]    db_estado;

   int nAsserts = 0;
   int nFails   = 0;

   detector_jogada #(
      .N_BOTOES        (NB),
      .DEBOUNCE_CICLOS (DB),
      .TIMEOUT_CICLOS  (TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .botoes       (botoes),
      .habilita     (habilita),
      .zeraT        (zeraT),
      .jogada       (jogada),
      .botao_codigo (botao_codigo),
      .timeout      (timeout),
      .db_estado    (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      // Reset state
      #1 reset = 1'b0;
      #2;
      check("rst_jogada", jogada, 0);
      check("rst_codigo", botao_codigo, 0);
      check("rst_timeout", timeout, 0);
      check("rst_estado", db_estado, LIVRE);
      step(2);
      reset = 1'b1;
      step(1);

      // Test 1: clean press of 0010 held 10 cycles
      habilita = 1'b1;
      botoes   = 4'b0010;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         check("t1_jogada", jogada, (i == 6));
         if (i == 1) check("t1_filtro", db_estado, FILTRO);
         if (i == 5) check("t1_pulso", db_estado, PULSO);
      end
      check("t1_codigo", botao_codigo, 4'b0010);
      check("t1_soltar", db_estado, SOLTAR);
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t1_no_repeat", jogada, 0);
      end
      botoes = '0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         check("t1_release_estado", db_estado, (i == 4) ? LIVRE : SOLTAR);
      end
      check("t1_codigo_held", botao_codigo, 4'b0010);

      // Test 2: glitchy press, valid move timed from the second press
      botoes = 4'b0100;
      for (int i = 0; i < 2; i++) begin
         step(1);
         check("t2_glitch_jogada", jogada, 0);
      end
      botoes = '0;
      step(1);
      check("t2_glitch_livre", db_estado, LIVRE);
      check("t2_glitch_jogada2", jogada, 0);
      botoes = 4'b0100;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         check("t2_jogada", jogada, (i == 6));
      end
      check("t2_codigo", botao_codigo, 4'b0100);
      botoes = '0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         check("t2_no_repeat", jogada, 0);
      end
      check("t2_livre", db_estado, LIVRE);

      // Test 3: two buttons together are rejected
      botoes = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t3_soltar", db_estado, SOLTAR);
         check("t3_jogada", jogada, 0);
      end
      botoes = '0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         check("t3_jogada_rel", jogada, 0);
      end
      check("t3_livre", db_estado, LIVRE);
      check("t3_codigo", botao_codigo, 4'b0100);
      check("t3_timeout", timeout, 0);

      // Test 4: timeout expiry, zeraT restart, then a move before expiry
      habilita = 1'b0;
      step(1);
      habilita = 1'b1;
      for (int i = 1; i <= TO; i++) begin
         step(1);
         check("t4_timeout", timeout, (i == TO));
      end
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("t4_timeout_hold", timeout, 1);
      end
      zeraT = 1'b1;
      step(1);
      zeraT = 1'b0;
      check("t4_zerat", timeout, 0);
      for (int i = 0; i < 9; i++) begin
         step(1);
         check("t4_recount", timeout, 0);
      end
      botoes = 4'b1000;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         check("t4_jogada", jogada, (i == 6));
         check("t4_no_timeout", timeout, 0);
      end
      check("t4_codigo", botao_codigo, 4'b1000);
      botoes = '0;
      step(4);
      check("t4_livre", db_estado, LIVRE);

      // Test 5: button held before habilita rises
      habilita = 1'b0;
      botoes   = 4'b0001;
      step(1);
      check("t5_soltar", db_estado, SOLTAR);
      step(2);
      habilita = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1);
         check("t5_held_jogada", jogada, 0);
      end
      check("t5_held_soltar", db_estado, SOLTAR);
      botoes = '0;
      for (int i = 1; i <= 4; i++) begin
         step(1);
         check("t5_rel_jogada", jogada, 0);
      end
      check("t5_livre", db_estado, LIVRE);
      botoes = 4'b0001;
      for (int i = 1; i <= 6; i++) begin
         step(1);
         check("t5_jogada", jogada, (i == 6));
      end
      check("t5_codigo", botao_codigo, 4'b0001);
      botoes = '0;
      step(4);
      check("t5_livre2", db_estado, LIVRE);

      // Test 6: asynchronous reset in the middle of FILTRO
      botoes = 4'b0010;
      step(2);
      check("t6_filtro", db_estado, FILTRO);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_jogada", jogada, 0);
      check("t6_rst_codigo", botao_codigo, 0);
      check("t6_rst_timeout", timeout, 0);
      check("t6_rst_estado", db_estado, LIVRE);
      step(1);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t6_held_jogada", jogada, 0);
      end
      botoes = '0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         check("t6_rel_jogada", jogada, 0);
      end
      check("t6_livre", db_estado, LIVRE);
      check("t6_codigo", botao_codigo, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
